// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: hides the FIFO's registered read latency
// behind a 2-entry buffer and emits a valid/ready stream with burst markers.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int BEAT_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    inflight;
  logic [1:0]              count;
  logic [DATA_WIDTH-1:0]   head;
  logic [DATA_WIDTH-1:0]   spare;
  logic [BEAT_W-1:0]       beat;
  logic                    pop;
  logic [2:0]              held;
  logic [2:0]              occ;
  logic [1:0]              left;

  assign m_valid = (count != 2'd0);
  assign m_data  = head;
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign pop     = m_valid & m_ready;
  assign held    = {1'b0, count} + {2'b0, inflight};
  assign occ     = held - {2'b0, pop};
  assign left    = count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (rd_en) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!rd_en) begin
          if (held != 3'd0) state_nxt = S_DRAIN;
          else              state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rd_en)
          state_nxt = S_RUN;
        else if (count == 2'd0 && !inflight)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A read is only issued if its word will have a slot when it lands
  always_comb begin
    fifo_rd = (state == S_RUN) & rd_en & !fifo_empty & (occ < 3'd2);
    idle    = (state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= '0;
      spare    <= '0;
      beat     <= '0;
    end else begin
      inflight <= fifo_rd;
      count    <= left + {1'b0, inflight};
      if (pop && count == 2'd2) head <= spare;
      if (inflight) begin
        if (left == 2'd0) head  <= fifo_data;
        else              spare <= fifo_data;
      end
      if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO model,
// expected beats queued at push time and checked by a monitor.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          idle;

  logic [DW-1:0] fq[$];
  logic [DW:0]   exp_q[$];
  int            rd_cyc[$];
  int            pop_cyc[$];
  int            tb_beat = 0;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .BEAT_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
    exp_q.push_back({(tb_beat == BL - 1), d});
    tb_beat = (tb_beat + 1) % BL;
  endtask

  task automatic fifo_model();
    forever begin
      @(posedge clk);
      if (fifo_rd && fq.size() > 0) begin
        fifo_data  <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
      end
    end
  endtask

  task automatic monitor();
    int outs = 0;
    bit hold = 0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        outs = 0;
        hold = 0;
      end else begin
        if (fifo_rd) begin
          rd_cyc.push_back(cyc);
          chk("rd_while_empty", fifo_empty, 1'b0);
        end
        if (hold && m_valid) begin
          chk("hold_data", m_data, hd);
          chk("hold_last", m_last, hl);
        end
        if (m_valid && m_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", m_data, 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e[DW-1:0]);
            chk("beat_last", m_last, e[DW]);
          end
        end
        outs = outs + int'(fifo_rd) - int'(m_valid && m_ready);
        chk("outstanding_le2", (outs <= 2), 1'b1);
        hold = m_valid && !m_ready;
        hd = m_data;
        hl = m_last;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
    chk(name, exp_q.size(), 0);
  endtask

  function automatic int gap(input int q[$], input int a, input int b);
    if (b >= q.size() || a >= q.size()) return -1;
    return q[b] - q[a];
  endfunction

  initial begin
    int rb;
    int pb;
    fork
      fifo_model();
      monitor();
    join_none

    // reset and idle
    #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_idle", idle, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("empty_no_rd", fifo_rd, 1'b0);
    end

    // streaming
    m_ready = 1'b1;
    rb = rd_cyc.size();
    pb = pop_cyc.size();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_drain("stream_drain", 40);
    chk("stream_rd_n", rd_cyc.size() - rb, 8);
    chk("stream_rd_span", gap(rd_cyc, rb, rb + 7), 7);
    chk("stream_latency", pop_cyc[pb] - rd_cyc[rb], 2);
    chk("stream_pop_span", gap(pop_cyc, pb, pb + 7), 7);

    // backpressure
    rb = rd_cyc.size();
    pb = pop_cyc.size();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int i = 0; i < 12; i++) begin
      m_ready = !(i >= 2 && i <= 8);
      if (i == 5) begin
        chk("bp_valid", m_valid, 1'b1);
        chk("bp_head", m_data, 32'h1);
      end
      tick();
    end
    m_ready = 1'b1;
    wait_drain("bp_drain", 40);
    chk("bp_rd_n", rd_cyc.size() - rb, 8);
    chk("bp_pop_n", pop_cyc.size() - pb, 8);

    // empty boundary
    rb = rd_cyc.size();
    push(32'hAA);
    for (int i = 0; i < 5; i++) tick();
    push(32'hBB);
    wait_drain("edge_drain", 20);
    chk("edge_rd_n", rd_cyc.size() - rb, 2);

    // async reset while buffer is full
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h11 + i));
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", m_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_last", m_last, 1'b0);
    chk("arst_rd", fifo_rd, 1'b0);
    chk("arst_idle", idle, 1'b1);
    exp_q.delete();
    fq.delete();
    fifo_empty = 1'b1;
    tb_beat = 0;
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();

    // pause and resume mid-burst
    rb = rd_cyc.size();
    for (int i = 0; i < 6; i++) push(DW'(32'h21 + i));
    tick();
    tick();
    rd_en = 1'b0;
    #1;
    chk("fall_no_rd", fifo_rd, 1'b0);
    tick();
    chk("drain_busy", idle, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (idle) break;
      tick();
    end
    chk("pause_idle", idle, 1'b1);
    chk("pause_left_exp", exp_q.size(), 4);
    chk("pause_left_fifo", fq.size(), 4);
    chk("pause_rd_n", rd_cyc.size() - rb, 2);
    rd_en = 1'b1;
    wait_drain("resume_drain", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO buffer. It pulls words from the FIFO through its read strobe and empty flag, and hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer. It presents the words on a valid/ready stream with a per-burst `m_last` marker. It sits between the FIFO and any downstream consumer that can apply backpressure, and sustains one word per cycle when the consumer is always ready.

## Interface
- `DATA_WIDTH`, 32, width of FIFO word and stream data
- `BURST_LEN`, 4, stream beats per burst; `m_last` marks beat `BURST_LEN-1` (≥1)
- `BEAT_W`, 2, width of beat counter, ≥ clog2(`BURST_LEN`) (min 1)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rd_en` in 1: enable issuing FIFO reads
- `fifo_empty` in 1: FIFO empty flag
- `fifo_data` in `DATA_WIDTH`: FIFO registered read data, valid the cycle after `fifo_rd`
- `fifo_rd` out 1: FIFO read strobe
- `m_data` out `DATA_WIDTH`: stream data
- `m_valid` out 1: stream data valid
- `m_last` out 1: last beat of burst
- `m_ready` in 1: consumer accepts beat
- `idle` out 1: nothing buffered or in flight and `rd_en` low

## Operation
- Internal state: `inflight` (0/1, read issued last cycle), buffer `count` (0..2), head/spare data regs, `beat` counter, FSM.
- FSM states:
  - IDLE → RUN when `rd_en`=1.
  - RUN → DRAIN when `rd_en`=0 and (`count`+`inflight`)>0.
  - RUN → IDLE when `rd_en`=0 and nothing held.
  - DRAIN → IDLE when `count`=0 and `inflight`=0.
  - DRAIN → RUN when `rd_en`=1.
- `idle` = (state==IDLE).
- `pop` = `m_valid` & `m_ready`.
- `fifo_rd` = state RUN & `rd_en` & !`fifo_empty` & (`count`+`inflight`−`pop`) < 2. Combinational. Never asserted while `fifo_empty`=1.
- Capture: when `inflight`=1, `fifo_data` is written into head if the buffer is empty after the pop, otherwise into spare.
- On `pop`, spare shifts into head. Order is strictly FIFO, with no loss and no duplication.
- `m_valid` = (`count`>0). `m_data` = head.
- `beat` increments modulo `BURST_LEN` on each `pop`. `m_last` = `m_valid` & (`beat`==`BURST_LEN`−1).
- `beat` is not cleared by `rd_en` toggling: a burst resumes where it stopped.
- Holding: `m_data`/`m_last` stay stable while `m_valid`=1 and `m_ready`=0.
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `idle`=1. Also `count`=0, `inflight`=0, `beat`=0, state IDLE.
- Reset mid-operation: all state is cleared immediately. Buffered and in-flight words are discarded and the FIFO is not re-read.

## Timing
- Latency: `fifo_rd` at cycle t → word in head at edge t+1 → `m_valid`=1 in cycle t+2 (2 cycles).
- Throughput: 1 word/cycle with `m_ready` held high and FIFO non-empty. In steady state `count`=1, `inflight`=1.
- Backpressure: with `m_ready`=0, at most 2 words are outstanding (`count`+`inflight`≤2). `fifo_rd` stays low until a pop frees a slot. When the slot frees, `fifo_rd` is asserted in the same cycle as the pop.
- FIFO single entry: read at t, `fifo_empty`=1 at t+1, so no second read is issued.
- `rd_en` falling in cycle t: no `fifo_rd` in cycle t. An in-flight word is still captured and delivered.
- Simultaneous capture and pop with `count`=1: head takes `fifo_data`, and `count` stays 1.

## Test plan
- Reset and idle: hold `rst_n`=0, `fifo_empty`=1. Require all outputs at reset values, `idle`=1, and `fifo_rd`=0 for 10 cycles after release with `rd_en`=1.
- Streaming: FIFO preloaded with 0x1..0x8, `rd_en`=1, `m_ready`=1. Require `fifo_rd` high 8 consecutive cycles, and `m_data` 0x1..0x8 on consecutive cycles starting 2 cycles after the first `fifo_rd`. Require `m_last` on 0x4 and 0x8.
- Backpressure: same data, `m_ready` low cycles 3–9. Require ≤2 reads outstanding, `m_data` held at 0x1 while stalled, and final order 0x1..0x8 without gaps or repeats.
- Empty boundary: one word 0xAA, then write 0xBB 5 cycles later. Require exactly 2 `fifo_rd` pulses, none while `fifo_empty`=1, and beats 0xAA then 0xBB.
- Pause and resume: deassert `rd_en` after beat 2 of a burst. Require the in-flight word delivered, then state DRAIN → IDLE and `idle`=1. After reasserting `rd_en`, require `m_last` on the 2nd new beat.
- Async reset mid-stream: pulse `rst_n` low while `count`=2. Require `m_valid`=0 immediately (before the next clock edge) and `beat` restarting at 0.
